// File: rtl/crossing_pkg.sv
// Shared types and elaboration helpers for the crossing-register controllers.
package crossing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_e;

  // True when a timer of width tw can represent the value lim.
  function automatic bit timerw_ok(input int unsigned tw, input int unsigned lim);
    if (tw >= 32) return 1'b1;
    return ((64'd1 << tw) > 64'(lim));
  endfunction

endpackage

// File: rtl/crossing_ctrl_timer.sv
// Saturating up-counter with synchronous clear and a sticky limit flag.
// The flag only returns to 0 on reset; clearing the count leaves it alone.
module crossing_ctrl_timer #(
  parameter int unsigned LIMIT = 1024,
  parameter int unsigned TW    = 11
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_flag
);

  localparam logic [TW-1:0] LIMIT_W  = TW'(LIMIT);
  localparam logic [TW-1:0] LIMIT_M1 = TW'(LIMIT - 1);

  logic [TW-1:0] r_count;

  // Count up to LIMIT and hold; the flag rises together with the count reaching LIMIT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
      o_flag  <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT_W)) begin
      r_count <= r_count + 1'b1;
      if (r_count == LIMIT_M1) o_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/crossing_reg_ctrl.sv
// Source-side sequencer for a no-reset crossing register.
// Loads the register, lets it settle, flips REQ_TOG, then waits for the
// matching ACK_TOG. Enqueues during a transfer coalesce into one shadow slot.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | nothing in flight, shadow empty
// LOAD      | REG_EN high, crossing register captures REG_D
// SETTLE    | holding REG_D stable before the request toggle flips
// WAIT_ACK  | request outstanding, waiting for ACK_TOG == REQ_TOG
module crossing_reg_ctrl
  import crossing_pkg::*;
#(
  parameter int unsigned width      = 1,
  parameter int unsigned holdCycles = 2,
  parameter int unsigned timeout    = 1024,
  parameter int unsigned timerw     = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENQ_VALID,
  input  logic [width-1:0] ENQ_DATA,
  output logic             REG_EN,
  output logic [width-1:0] REG_D,
  output logic             REQ_TOG,
  input  logic             ACK_TOG,
  output logic             BUSY,
  output logic             OVERWRITE,
  output logic             TIMEOUT
);

  localparam int unsigned CNTW = $clog2(holdCycles + 1);

  if (holdCycles < 1) begin : g_bad_hold
    $error("crossing_reg_ctrl: holdCycles must be at least 1");
  end
  if (timeout < 1) begin : g_bad_timeout
    $error("crossing_reg_ctrl: timeout must be at least 1");
  end
  if (!timerw_ok(timerw, timeout)) begin : g_bad_timerw
    $error("crossing_reg_ctrl: timerw too narrow for timeout");
  end

  state_e            r_state;
  logic [CNTW-1:0]   r_cnt;
  logic [width-1:0]  r_shadow;
  logic              r_shadow_vld;

  logic w_ack;
  logic w_settle_done;
  logic w_capture;
  logic w_tmr_clr;
  logic w_tmr_inc;

  // Ack is only meaningful in WAIT_ACK; elsewhere the toggles match trivially.
  assign w_ack         = (ACK_TOG == REQ_TOG);
  assign w_settle_done = (r_state == ST_SETTLE) && (r_cnt == CNTW'(1));
  assign w_capture     = ENQ_VALID && (r_state != ST_IDLE) &&
                         !((r_state == ST_WAIT_ACK) && w_ack);
  assign w_tmr_clr     = w_settle_done;
  assign w_tmr_inc     = (r_state == ST_WAIT_ACK);

  // Transfer sequencing FSM with registered outputs and shadow slot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      REG_EN       <= 1'b0;
      REG_D        <= '0;
      REQ_TOG      <= 1'b0;
      BUSY         <= 1'b0;
      OVERWRITE    <= 1'b0;
    end else begin
      REG_EN    <= 1'b0;
      OVERWRITE <= 1'b0;

      // Mid-transfer enqueue: newest value wins, report a discarded one.
      if (w_capture) begin
        r_shadow     <= ENQ_DATA;
        r_shadow_vld <= 1'b1;
        OVERWRITE    <= r_shadow_vld;
      end

      case (r_state)
        ST_IDLE: begin
          if (ENQ_VALID) begin
            REG_D   <= ENQ_DATA;
            REG_EN  <= 1'b1;
            BUSY    <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cnt   <= CNTW'(holdCycles);
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_settle_done) begin
            REQ_TOG <= ~REQ_TOG;
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (w_ack) begin
            if (ENQ_VALID) begin
              REG_D        <= ENQ_DATA;
              REG_EN       <= 1'b1;
              r_shadow_vld <= 1'b0;
              OVERWRITE    <= r_shadow_vld;
              r_state      <= ST_LOAD;
            end else if (r_shadow_vld) begin
              REG_D        <= r_shadow;
              REG_EN       <= 1'b1;
              r_shadow_vld <= 1'b0;
              r_state      <= ST_LOAD;
            end else begin
              BUSY    <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  crossing_ctrl_timer #(
    .LIMIT (timeout),
    .TW    (timerw)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .i_clr  (w_tmr_clr),
    .i_inc  (w_tmr_inc),
    .o_flag (TIMEOUT)
  );

endmodule

// File: tb/tb_crossing_reg_ctrl.sv
// Directed and randomized bench for crossing_reg_ctrl (width=4, holdCycles=2, timeout=8).
module tb_crossing_reg_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ENQ_VALID = 1'b0;
  logic [3:0] ENQ_DATA = 4'h0;
  logic       REG_EN;
  logic [3:0] REG_D;
  logic       REQ_TOG;
  logic       ACK_TOG = 1'b0;
  logic       BUSY;
  logic       OVERWRITE;
  logic       TIMEOUT;

  int n_checks = 0;
  int n_err    = 0;

  // random-phase tracking
  logic [3:0] prev_d;
  logic       prev_req;
  logic [3:0] last_enq;
  logic [3:0] last_loaded;
  int         n_loads = 0;
  int         n_flips = 0;
  int         dly = 0;
  int         budget;

  crossing_reg_ctrl #(
    .width(4), .holdCycles(2), .timeout(8), .timerw(4)
  ) dut (
    .CLK(CLK), .RST(RST), .ENQ_VALID(ENQ_VALID), .ENQ_DATA(ENQ_DATA),
    .REG_EN(REG_EN), .REG_D(REG_D), .REQ_TOG(REQ_TOG), .ACK_TOG(ACK_TOG),
    .BUSY(BUSY), .OVERWRITE(OVERWRITE), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor_cycle();
    if (REG_EN) begin
      n_loads++;
      last_loaded = REG_D;
    end else begin
      chk("regd_stable", {28'd0, REG_D}, {28'd0, prev_d});
    end
    if (REQ_TOG != prev_req) n_flips++;
    chk("req_per_load", {31'd0, (n_loads == n_flips) || (n_loads == n_flips + 1)}, 32'd1);
    prev_d   = REG_D;
    prev_req = REQ_TOG;
  endtask

  task automatic ack_responder();
    if (REQ_TOG != ACK_TOG) begin
      if (dly == 0) begin
        ACK_TOG = REQ_TOG;
        dly = $urandom_range(0, 4);
      end else begin
        dly--;
      end
    end
  endtask

  initial begin
    // reset
    tick(); tick();
    chk("rst_reg_en", {31'd0, REG_EN}, 0);
    chk("rst_reg_d", {28'd0, REG_D}, 0);
    chk("rst_req", {31'd0, REQ_TOG}, 0);
    chk("rst_busy", {31'd0, BUSY}, 0);
    chk("rst_ovw", {31'd0, OVERWRITE}, 0);
    chk("rst_timeout", {31'd0, TIMEOUT}, 0);
    RST = 1'b0;

    // scenario 1: single transfer of 0x5
    ENQ_VALID = 1'b1; ENQ_DATA = 4'h5;
    tick();                                   // cycle 1
    chk("s1_reg_en_c1", {31'd0, REG_EN}, 1);
    chk("s1_reg_d_c1", {28'd0, REG_D}, 32'h5);
    chk("s1_busy_c1", {31'd0, BUSY}, 1);
    ENQ_VALID = 1'b0;
    tick();                                   // cycle 2
    chk("s1_reg_en_c2", {31'd0, REG_EN}, 0);
    tick();                                   // cycle 3
    chk("s1_req_c3", {31'd0, REQ_TOG}, 0);
    tick();                                   // cycle 4
    chk("s1_req_c4", {31'd0, REQ_TOG}, 1);
    tick(); tick(); tick();                   // cycle 7
    chk("s1_busy_c7", {31'd0, BUSY}, 1);
    ACK_TOG = 1'b1;
    tick();                                   // cycle 8
    chk("s1_busy_c8", {31'd0, BUSY}, 0);
    chk("s1_reg_en_c8", {31'd0, REG_EN}, 0);

    // scenario 2: two enqueues in WAIT_ACK coalesce, newest delivered
    ENQ_VALID = 1'b1; ENQ_DATA = 4'h1;
    tick();
    chk("s2_load_d", {28'd0, REG_D}, 32'h1);
    ENQ_VALID = 1'b0;
    tick(); tick(); tick();
    chk("s2_req_flip", {31'd0, REQ_TOG}, 0);
    ENQ_VALID = 1'b1; ENQ_DATA = 4'hA;
    tick();
    chk("s2_ovw_first", {31'd0, OVERWRITE}, 0);
    ENQ_DATA = 4'hB;
    tick();
    chk("s2_ovw_second", {31'd0, OVERWRITE}, 1);
    ENQ_VALID = 1'b0;
    tick();
    chk("s2_ovw_after", {31'd0, OVERWRITE}, 0);
    chk("s2_reg_d_held", {28'd0, REG_D}, 32'h1);
    chk("s2_busy", {31'd0, BUSY}, 1);
    ACK_TOG = 1'b0;
    tick();
    chk("s2_reload_en", {31'd0, REG_EN}, 1);
    chk("s2_reload_d", {28'd0, REG_D}, 32'hB);
    tick(); tick(); tick();
    chk("s2_req_flip2", {31'd0, REQ_TOG}, 1);

    // scenario 3: enqueue in the ack cycle replaces a pending shadow
    ENQ_VALID = 1'b1; ENQ_DATA = 4'h3;
    tick();
    chk("s3_ovw_fill", {31'd0, OVERWRITE}, 0);
    ENQ_DATA = 4'hC; ACK_TOG = 1'b1;
    tick();
    chk("s3_reg_en", {31'd0, REG_EN}, 1);
    chk("s3_reg_d", {28'd0, REG_D}, 32'hC);
    chk("s3_ovw", {31'd0, OVERWRITE}, 1);
    chk("s3_busy", {31'd0, BUSY}, 1);
    ENQ_VALID = 1'b0;
    tick(); tick(); tick();
    chk("s3_req", {31'd0, REQ_TOG}, 0);
    ACK_TOG = 1'b0;
    tick();
    chk("s3_idle", {31'd0, BUSY}, 0);
    chk("s3_no_reload", {31'd0, REG_EN}, 0);

    // scenario 4: missing ack raises sticky TIMEOUT after 8 WAIT_ACK cycles
    ENQ_VALID = 1'b1; ENQ_DATA = 4'h7;
    tick();
    ENQ_VALID = 1'b0;
    tick(); tick(); tick();
    chk("s4_req", {31'd0, REQ_TOG}, 1);
    chk("s4_to_w0", {31'd0, TIMEOUT}, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("s4_to_w%0d", k), {31'd0, TIMEOUT}, {31'd0, k == 8});
    end
    chk("s4_busy", {31'd0, BUSY}, 1);
    ACK_TOG = 1'b1;
    tick();
    chk("s4_done_busy", {31'd0, BUSY}, 0);
    chk("s4_to_sticky", {31'd0, TIMEOUT}, 1);
    tick();
    chk("s4_to_sticky2", {31'd0, TIMEOUT}, 1);

    // scenario 5: reset during SETTLE with shadow valid
    ENQ_VALID = 1'b1; ENQ_DATA = 4'h9;
    tick();
    ENQ_DATA = 4'h6;
    tick();
    ENQ_VALID = 1'b0; RST = 1'b1; ACK_TOG = 1'b0;
    tick();
    chk("s5_reg_en", {31'd0, REG_EN}, 0);
    chk("s5_reg_d", {28'd0, REG_D}, 0);
    chk("s5_req", {31'd0, REQ_TOG}, 0);
    chk("s5_busy", {31'd0, BUSY}, 0);
    chk("s5_ovw", {31'd0, OVERWRITE}, 0);
    chk("s5_timeout", {31'd0, TIMEOUT}, 0);
    RST = 1'b0;
    ENQ_VALID = 1'b1; ENQ_DATA = 4'h5;
    tick();
    chk("s5_reg_en_c1", {31'd0, REG_EN}, 1);
    chk("s5_reg_d_c1", {28'd0, REG_D}, 32'h5);
    ENQ_VALID = 1'b0;
    tick(); tick();
    chk("s5_req_c3", {31'd0, REQ_TOG}, 0);
    tick();
    chk("s5_req_c4", {31'd0, REQ_TOG}, 1);
    ACK_TOG = 1'b1;
    tick();
    chk("s5_idle", {31'd0, BUSY}, 0);
    tick();
    chk("s5_shadow_lost", {31'd0, REG_EN}, 0);
    chk("s5_still_idle", {31'd0, BUSY}, 0);

    // scenario 6: random enqueues with a delayed ack responder
    prev_d = REG_D; prev_req = REQ_TOG;
    last_enq = 4'h5; last_loaded = 4'h5;
    for (int c = 0; c < 400; c++) begin
      monitor_cycle();
      if ($urandom_range(0, 3) == 0) begin
        ENQ_VALID = 1'b1;
        ENQ_DATA  = 4'($urandom_range(0, 15));
        last_enq  = ENQ_DATA;
      end else begin
        ENQ_VALID = 1'b0;
      end
      ack_responder();
      tick();
    end
    ENQ_VALID = 1'b0;
    budget = 100;
    while (budget > 0 && !(BUSY == 1'b0 && REQ_TOG == ACK_TOG)) begin
      monitor_cycle();
      ack_responder();
      tick();
      budget--;
    end
    monitor_cycle();
    chk("r_drain_idle", {31'd0, BUSY}, 0);
    chk("r_last_delivered", {28'd0, last_loaded}, {28'd0, last_enq});
    chk("r_no_timeout", {31'd0, TIMEOUT}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
